// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed request-to-resp latency and a held-request handshake.
// Optional macro MEM_RESP_ERR_EN adds resp_err for misaligned or out-of-range addresses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [3:0]  mbe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        resp_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [3:0]    mbe_q;
  logic [31:0]   wdata_q;
  logic          wr_q, both_q, err_q;
  logic          accept, commit, req_err;
  logic [AW-1:0] cur_idx;
  logic [3:0]    cur_mbe;
  logic [31:0]   cur_wdata;
  logic          cur_wr, cur_both, cur_err;
  logic [31:0]   mem [DEPTH_WORDS];

`ifdef MEM_RESP_ERR_EN
  assign req_err  = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
  assign resp_err = (state == RESP) && err_q;
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

  assign accept = (state == IDLE) && (read || write);
  // Commit happens on the edge entering RESP; gated by reset so memory never sees a write while reset is held.
  assign commit = reset && (state != RESP) && (state_nxt == RESP);
  assign resp   = (state == RESP);

  // With LATENCY=1 the commit edge is also the accept edge, so use live inputs then.
  always_comb begin
    cur_idx   = idx_q;
    cur_mbe   = mbe_q;
    cur_wdata = wdata_q;
    cur_wr    = wr_q;
    cur_both  = both_q;
    cur_err   = err_q;
    if (accept) begin
      cur_idx   = addr[AW+1:2];
      cur_mbe   = mbe;
      cur_wdata = wdata;
      cur_wr    = write;
      cur_both  = read && write;
      cur_err   = req_err;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read || write) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      mbe_q   <= 4'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        idx_q   <= addr[AW+1:2];
        mbe_q   <= mbe;
        wdata_q <= wdata;
        wr_q    <= write;
        both_q  <= read && write;
        err_q   <= req_err;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // Plain writes leave rdata holding its previous value.
      if (commit) begin
        if (cur_err || cur_both) rdata <= 32'd0;
        else if (!cur_wr)        rdata <= mem[cur_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cur_wr && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_mbe[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes expected responses, negedge monitor pops and compares.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  mbe = 4'd0;
  logic [31:0] rdata;
  logic        resp;
`ifdef MEM_RESP_ERR_EN
  logic        resp_err;
`endif

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .mbe(mbe), .wdata(wdata), .rdata(rdata), .resp(resp)
`ifdef MEM_RESP_ERR_EN
    , .resp_err(resp_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_held = 32'd0;
  logic [31:0] mon_held = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a transaction raised in cycle n answers in cycle n+LAT and updates a flat word array.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input int mode);
    exp_t e;
    int   i;
    bit   er;
    read = rd; write = wr; addr = a; mbe = m; wdata = d;
    i = int'(a[AW+1:2]);
`ifdef MEM_RESP_ERR_EN
    er = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
`else
    er = 1'b0;
`endif
    if (er) model_held = 32'd0;
    else if (wr) begin
      for (int b = 0; b < 4; b++) if (m[b]) model_mem[i][8*b +: 8] = d[8*b +: 8];
      if (rd) model_held = 32'd0;
    end else model_held = model_mem[i];
    e.cyc = cyc + LAT; e.rdata = model_held; e.err = er;
    sb.push_back(e);
    if (mode == 2) begin
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
    end
    while (cyc <= e.cyc) begin
      @(posedge clk); #1;
    end
    if (mode != 1) begin
      read = 1'b0; write = 1'b0;
    end
  endtask

  function automatic logic [31:0] mk_addr(input int w);
    logic [31:0] r;
    logic [31:0] base;
    r = $urandom;
    base = 32'(w) << 2;
`ifdef MEM_RESP_ERR_EN
    if (r[31:29] == 3'b000) return r;
    return base;
`else
    return (r & ~32'((DEPTH * 4) - 1)) | base | {30'd0, r[1:0]};
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) mon_held = 32'd0;
    if (resp === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_resp: resp=1 at cycle %0d, required 0 (nothing outstanding)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("rdata", rdata, mon_e.rdata);
`ifdef MEM_RESP_ERR_EN
        check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
`endif
        mon_held = mon_e.rdata;
      end
    end else begin
      check("rdata_hold", rdata, mon_held);
`ifdef MEM_RESP_ERR_EN
      check("resp_err_idle", {31'd0, resp_err}, 32'd0);
`endif
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        vectors++; miscompares++;
        $display("FAIL resp_missing: no resp by cycle %0d, expected at cycle %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_mode;
    int op, mode, gap;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < DEPTH; w++) issue(1'b0, 1'b1, mk_addr(w), 4'hF, $urandom, 0);

    issue(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0);
    issue(1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344, 0);
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0);
    // Three reads with the request held continuously.
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1);
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1);
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0);

    // Write accepted, then reset during WAIT: must neither commit nor respond.
    read = 1'b0; write = 1'b1; addr = 32'h20; mbe = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    reset = 1'b0; write = 1'b0; model_held = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 0);

    issue(1'b1, 1'b1, 32'h8, 4'hF, 32'h5A5A5A5A, 0);
    issue(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 0);
    issue(1'b0, 1'b1, 32'h30, 4'hF, 32'h13579BDF, 2);
    issue(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, 0);
    issue(1'b0, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, 0);
    issue(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 0);
`ifdef MEM_RESP_ERR_EN
    issue(1'b0, 1'b1, 32'h13, 4'hF, 32'h0BADF00D, 0);
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0);
    issue(1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 0);
`endif

    prev_mode = 0;
    for (int n = 0; n < 300; n++) begin
      if (prev_mode != 1) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
      op   = $urandom_range(0, 3);
      mode = (n == 299) ? 0 : $urandom_range(0, 2);
      issue(op == 0 || op == 2 || op == 3, op == 1 || op == 2,
            mk_addr($urandom_range(0, 15)), 4'($urandom), $urandom, mode);
      prev_mode = mode;
    end

    repeat (LAT + 4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
